rc_vc_unit: RTL

- Registered, per-virtual-channel route computation stage for the router input port; successor to the combinational DOR route computer.
- Computes the output port once per packet on the head flit and holds it for that VC until the packet fully drains. Release is signalled by downstream allocation.
- Adds run-time selection of XY/YX dimension order and optional destination/protocol checking.
- Sits between the input buffer write side and the VC/switch allocators.

---
 rtl/rc_vc_unit_pkg.sv | 41 ++++
 rtl/rc_vc_unit_if.sv | 39 +++
 rtl/rc_vc_unit_route_fn.sv | 56 +++++
 rtl/rc_vc_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rc_vc_unit_pkg.sv
// noc_params: shared NoC types for the registered per-VC route computation stage.
`default_nettype none

package noc_params;

  localparam int DEF_MESH_SIZE_X = 4;
  localparam int DEF_MESH_SIZE_Y = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic {
    RC_XY = 1'b0,
    RC_YX = 1'b1
  } rc_mode_t;

  typedef enum logic [1:0] {
    RC_IDLE     = 2'd0,
    RC_ROUTED   = 2'd1,
    RC_DRAINING = 2'd2
  } rc_state_t;

  function automatic logic is_head(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc_vc_unit_if.sv
// rc_vc_unit_if: flit write side, release inputs and per-VC route outputs.
`default_nettype none

interface rc_vc_unit_if
  import noc_params::*;
#(
  parameter int VC_NUM           = 2,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4
);

  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic                        flit_valid_i;
  logic [VCW-1:0]              flit_vc_i;
  flit_label_t                 flit_label_i;
  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i;
  logic                        route_mode_i;
  logic [VC_NUM-1:0]           rc_release_i;
  logic [VC_NUM-1:0]           rc_valid_o;
  port_t                       out_port_o [VC_NUM];
  logic [VC_NUM-1:0]           rc_err_o;

  modport master (
    output flit_valid_i, flit_vc_i, flit_label_i, x_dest_i, y_dest_i,
           route_mode_i, rc_release_i,
    input  rc_valid_o, out_port_o, rc_err_o
  );

  modport slave (
    input  flit_valid_i, flit_vc_i, flit_label_i, x_dest_i, y_dest_i,
           route_mode_i, rc_release_i,
    output rc_valid_o, out_port_o, rc_err_o
  );

endinterface

`default_nettype wire

// File: rtl/rc_vc_unit_route_fn.sv
// rc_route_fn: combinational XY/YX dimension-order route function.
// Bounds flag is only produced when RC_ERR_CHECK_EN is defined.
`default_nettype none

module rc_route_fn
  import noc_params::*;
#(
  parameter int X_CURRENT        = 0,
  parameter int Y_CURRENT        = 0,
  parameter int MESH_SIZE_X      = DEF_MESH_SIZE_X,
  parameter int MESH_SIZE_Y      = DEF_MESH_SIZE_Y,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4
) (
  input  logic [DEST_ADDR_SIZE_X-1:0] i_x_dest,
  input  logic [DEST_ADDR_SIZE_Y-1:0] i_y_dest,
  input  rc_mode_t                    i_mode,
  output port_t                       o_port,
  output logic                        o_out_of_range
);

  localparam logic [DEST_ADDR_SIZE_X-1:0] c_X_CUR = DEST_ADDR_SIZE_X'(X_CURRENT);
  localparam logic [DEST_ADDR_SIZE_Y-1:0] c_Y_CUR = DEST_ADDR_SIZE_Y'(Y_CURRENT);

  port_t w_x_port;
  port_t w_y_port;

  // Plain unsigned compares: no subtraction, so no wrap-around at the mesh edge.
  always_comb begin
    w_x_port = LOCAL;
    if (i_x_dest < c_X_CUR)      w_x_port = WEST;
    else if (i_x_dest > c_X_CUR) w_x_port = EAST;
  end

  always_comb begin
    w_y_port = LOCAL;
    if (i_y_dest < c_Y_CUR)      w_y_port = NORTH;
    else if (i_y_dest > c_Y_CUR) w_y_port = SOUTH;
  end

  always_comb begin
    o_port = LOCAL;
    if (i_mode == RC_XY) o_port = (w_x_port != LOCAL) ? w_x_port : w_y_port;
    else                 o_port = (w_y_port != LOCAL) ? w_y_port : w_x_port;
  end

`ifdef RC_ERR_CHECK_EN
  assign o_out_of_range = (32'(i_x_dest) >= 32'(MESH_SIZE_X)) ||
                          (32'(i_y_dest) >= 32'(MESH_SIZE_Y));
`else
  assign o_out_of_range = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/rc_vc_unit.sv
// rc_vc_unit: registered per-VC route computation, held until downstream release.
// Optional sticky bounds/protocol error flags when RC_ERR_CHECK_EN is defined.
`default_nettype none

module rc_vc_unit
  import noc_params::*;
#(
  parameter int X_CURRENT        = 0,
  parameter int Y_CURRENT        = 0,
  parameter int MESH_SIZE_X      = DEF_MESH_SIZE_X,
  parameter int MESH_SIZE_Y      = DEF_MESH_SIZE_Y,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4,
  parameter int VC_NUM           = 2
) (
  input  logic         clk,
  input  logic         rst,
  rc_vc_unit_if.slave  bus
);

  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  port_t             w_route;
  port_t             w_route_eff;
  logic              w_oor;
  logic              w_head;
  logic [VC_NUM-1:0] w_valid;
  logic [VC_NUM-1:0] w_err;
  port_t             w_port [VC_NUM];

  // One head per cycle at most, so a single shared route function suffices.
  rc_route_fn #(
    .X_CURRENT        (X_CURRENT),
    .Y_CURRENT        (Y_CURRENT),
    .MESH_SIZE_X      (MESH_SIZE_X),
    .MESH_SIZE_Y      (MESH_SIZE_Y),
    .DEST_ADDR_SIZE_X (DEST_ADDR_SIZE_X),
    .DEST_ADDR_SIZE_Y (DEST_ADDR_SIZE_Y)
  ) u_route_fn (
    .i_x_dest       (bus.x_dest_i),
    .i_y_dest       (bus.y_dest_i),
    .i_mode         (rc_mode_t'(bus.route_mode_i)),
    .o_port         (w_route),
    .o_out_of_range (w_oor)
  );

  assign w_route_eff = w_oor ? LOCAL : w_route;
  assign w_head      = is_head(bus.flit_label_i);

  generate
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      rc_state_t r_state;
      rc_state_t w_next;
      port_t     r_port;
      logic      w_hit;
      logic      w_rel;
      logic      w_latch;
      logic      w_valid_v;

      assign w_hit = bus.flit_valid_i && (bus.flit_vc_i == VCW'(v));
      assign w_rel = bus.rc_release_i[v];

      always_ff @(posedge clk) begin
        if (rst) r_state <= RC_IDLE;
        else     r_state <= w_next;
      end

      always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
          RC_IDLE: begin
            if (w_hit && w_head) begin
              w_latch = 1'b1;
              w_next  = (bus.flit_label_i == HEAD) ? RC_ROUTED : RC_DRAINING;
            end
          end
          RC_ROUTED: begin
            if (w_hit && (bus.flit_label_i == TAIL)) w_next = RC_DRAINING;
          end
          RC_DRAINING: begin
            // A head arriving with the release starts the next packet without a bubble.
            if (w_rel) begin
              if (w_hit && w_head) begin
                w_latch = 1'b1;
                w_next  = (bus.flit_label_i == HEAD) ? RC_ROUTED : RC_DRAINING;
              end else begin
                w_next = RC_IDLE;
              end
            end
          end
          default: w_next = RC_IDLE;
        endcase
      end

      always_comb begin
        w_valid_v = (r_state != RC_IDLE);
      end

      always_ff @(posedge clk) begin
        if (rst)          r_port <= LOCAL;
        else if (w_latch) r_port <= w_route_eff;
      end

      assign w_valid[v] = w_valid_v;
      assign w_port[v]  = r_port;

`ifdef RC_ERR_CHECK_EN
      logic r_err;
      logic w_viol;

      assign w_viol = w_hit && (((r_state == RC_IDLE) && !w_head) ||
                                ((r_state == RC_ROUTED) && w_head) ||
                                ((r_state == RC_DRAINING) && !(w_rel && w_head)));

      always_ff @(posedge clk) begin
        if (rst)                               r_err <= 1'b0;
        else if ((w_latch && w_oor) || w_viol) r_err <= 1'b1;
      end

      assign w_err[v] = r_err;
`else
      assign w_err[v] = 1'b0;
`endif
    end
  endgenerate

  assign bus.rc_valid_o = w_valid;
  assign bus.out_port_o = w_port;
  assign bus.rc_err_o   = w_err;

endmodule

`default_nettype wire
